fb_rect_writer: RTL and testbench
=================================

Name: fb_rect_writer

Overview:
- Upstream drawing stage for the double-buffered 160x120 VGA framebuffer.
- Accepts one rectangle-fill command at a time over a valid/ready handshake and clips it to the virtual screen.
- Emits a one-write-per-cycle stream (address, 24-bit colour, write enable) into the framebuffer's write-buffer port.
- Addressing is column-major, matching the read side: addr = x*VIRT_H + y.

Parameters:
- VIRT_W, 160, virtual pixel columns.
- VIRT_H, 120, virtual pixel rows.
- ADDR_W, 15, framebuffer address width.
- COLOR_W, 24, colour word width {R,G,B}.

Ports:
- clk  input  1  system clock (50 MHz).
- rst  input  1  synchronous reset, active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- cmd_x0  input  8  left column.
- cmd_y0  input  8  top row.
- cmd_w  input  8  width in virtual pixels.
- cmd_h  input  8  height in virtual pixels.
- cmd_color  input  COLOR_W  fill colour.
- wr_addr  output  ADDR_W  framebuffer write address.
- wr_data  output  COLOR_W  framebuffer write data.
- wr_en  output  1  write request.
- wr_ready  input  1  framebuffer/arbiter accepts the write this cycle.
- busy  output  1  command in progress (any state other than IDLE).
- done  output  1  one-cycle pulse when a command completes.

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high (rst).
- Reset: all outputs are 0 while rst is high (cmd_ready gated low). State returns to IDLE. Counters clear.
- States:
  - IDLE: cmd_ready=1. On cmd_valid, latch the command, go to SETUP.
  - SETUP: compute clipped bounds. Go to FILL if non-empty, else DONE.
  - FILL: emit writes.
  - DONE: done=1 for one cycle, then IDLE.
- Clipping uses 9-bit arithmetic so sums never overflow:
  - x_end = min(x0+w, VIRT_W); y_end = min(y0+h, VIRT_H).
  - The rectangle is empty if w==0, h==0, x0>=VIRT_W, or y0>=VIRT_H.
- Address generation is incremental; no multiplier in the FILL loop.
  - Start address = x0*VIRT_H + y0, computed in SETUP.
  - Within a column: addr+1.
  - At column end: addr += VIRT_H - (y_end - y0 - 1).
- Order: outer loop x ascending, inner loop y ascending.
- Latency: accept at cycle N → first wr_en at N+2. Empty command → done at N+2, no wr_en.
- Write handshake:
  - A write is consumed when wr_en && wr_ready.
  - While wr_en && !wr_ready, wr_addr and wr_data hold and the counters do not advance.
  - wr_en stays high in FILL until the last write is consumed.
- Completion: state enters DONE on the cycle after the last consumed write. wr_en=0 in DONE. cmd_ready returns the cycle after done.
- A command presented while busy is not accepted; cmd_ready stays 0.
- wr_data = latched cmd_color for the whole command. Later changes on the cmd_* inputs have no effect.
- Reset mid-FILL: wr_en=0 from the next edge, the partial rectangle stays in memory, and no done pulse is generated.
- The maximum command (0,0,255,255) clips to 160x120 = 19200 writes, addr 0..19199. The address never exceeds MEMORY_SIZE-1.

Decomposition:
- Shared package fb_pkg holds:
  - VIRT_W=160, VIRT_H=120, PIXEL_VIRTUAL_SIZE=4, MEMORY_SIZE=19200, ADDR_W=15, COLOR_W=24.
  - State encoding (IDLE/SETUP/FILL/DONE).
  - A rect command struct (x0, y0, w, h, color).
- One natural sub-module: fb_rect_clip, purely combinational. It maps a command to clipped x_end, y_end, an empty flag and the start address, and is reusable by future sprite/line writers.

Test Plan:
- Basic fill: after reset, cmd (x0=2, y0=3, w=2, h=3, color=FF0000) with wr_ready=1.
  - Required: exactly 6 writes, addrs 243, 244, 245, 363, 364, 365, data FF0000.
  - First wr_en 2 cycles after accept; done pulses 1 cycle after the last write.
- Clipping: cmd (158, 118, 5, 5, 00FF00).
  - Required: 4 writes at addrs 18978, 18979, 19198, 19199; no address ≥19200.
- Empty commands: w=0, and separately x0=160.
  - Required: no wr_en; done pulses exactly 2 cycles after accept; cmd_ready high the cycle after.
- Backpressure: cmd (10, 10, 1, 4, 0000FF) with wr_ready low for 3 cycles after the second write.
  - Required: wr_addr holds at 1212 while stalled.
  - Total writes 1210..1213, none duplicated or skipped.
- Full clear: cmd (0, 0, 255, 255, 000000).
  - Required: 19200 consecutive writes, addr 0..19199 strictly sequential, then done.
  - cmd_ready=0 throughout; a second cmd_valid during the fill is ignored.
- Reset mid-fill: assert rst at write 100 of a full clear.
  - Required: wr_en=0 next cycle, no done pulse.
  - After rst deasserts, cmd_ready=1 and a new command is accepted normally.

Source files
------------

// File: rtl/fb_pkg.sv
// ---------------------------------------------------------------------------
// fb_pkg
// Shared constants and types for the 160x120 virtual framebuffer and the
// drawing stages that write into it.
//   VIRT_W / VIRT_H      : virtual screen size in pixels
//   PIXEL_VIRTUAL_SIZE   : physical pixels per virtual pixel (read side)
//   MEMORY_SIZE          : framebuffer depth in words
//   ADDR_W / COLOR_W     : framebuffer address and colour widths
//   fill_state_t         : rectangle writer FSM encoding
//   rect_geom_t          : rectangle geometry (shared with future writers)
//   rect_cmd_t           : full fill command (geometry + colour)
// ---------------------------------------------------------------------------
package fb_pkg;

    localparam int VIRT_W             = 160;
    localparam int VIRT_H             = 120;
    localparam int PIXEL_VIRTUAL_SIZE = 4;
    localparam int MEMORY_SIZE        = VIRT_W * VIRT_H;
    localparam int ADDR_W             = 15;
    localparam int COLOR_W            = 24;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_FILL,
        ST_DONE
    } fill_state_t;

    typedef struct packed {
        logic [7:0] x0;
        logic [7:0] y0;
        logic [7:0] w;
        logic [7:0] h;
    } rect_geom_t;

    typedef struct packed {
        rect_geom_t         geom;
        logic [COLOR_W-1:0] color;
    } rect_cmd_t;

endpackage

// File: rtl/fb_rect_writer_if.sv
// ---------------------------------------------------------------------------
// fb_rect_writer_if
// Command and write-stream signals of the rectangle writer.
//   slave  : the writer block (accepts commands, produces writes)
//   master : the surrounding system (issues commands, sinks writes)
// Signals:
//   cmd_valid/cmd_ready            command handshake
//   cmd_x0/cmd_y0/cmd_w/cmd_h      rectangle geometry
//   cmd_color                      fill colour {R,G,B}
//   wr_addr/wr_data/wr_en/wr_ready framebuffer write stream
//   busy/done                      command status
// ---------------------------------------------------------------------------
interface fb_rect_writer_if;
    import fb_pkg::*;

    logic               cmd_valid;
    logic               cmd_ready;
    logic [7:0]         cmd_x0;
    logic [7:0]         cmd_y0;
    logic [7:0]         cmd_w;
    logic [7:0]         cmd_h;
    logic [COLOR_W-1:0] cmd_color;
    logic [ADDR_W-1:0]  wr_addr;
    logic [COLOR_W-1:0] wr_data;
    logic               wr_en;
    logic               wr_ready;
    logic               busy;
    logic               done;

    modport slave (
        input  cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color, wr_ready,
        output cmd_ready, wr_addr, wr_data, wr_en, busy, done
    );

    modport master (
        output cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color, wr_ready,
        input  cmd_ready, wr_addr, wr_data, wr_en, busy, done
    );

endinterface

// File: rtl/fb_rect_clip.sv
// ---------------------------------------------------------------------------
// fb_rect_clip
// Purely combinational clipper: maps a rectangle to the virtual screen.
//   geom       : x0, y0, w, h of the requested rectangle
//   x_end      : exclusive right bound, min(x0+w, VIRT_W)
//   y_end      : exclusive bottom bound, min(y0+h, VIRT_H)
//   empty      : nothing of the rectangle lands on screen
//   start_addr : column-major address of (x0, y0); meaningful only if !empty
// ---------------------------------------------------------------------------
module fb_rect_clip
    import fb_pkg::*;
(
    input  rect_geom_t        geom,
    output logic [7:0]        x_end,
    output logic [7:0]        y_end,
    output logic              empty,
    output logic [ADDR_W-1:0] start_addr
);

    // 9-bit sums so x0+w / y0+h cannot wrap before the clamp.
    logic [8:0] x_sum;
    logic [8:0] y_sum;

    always_comb begin
        x_sum = {1'b0, geom.x0} + {1'b0, geom.w};
        y_sum = {1'b0, geom.y0} + {1'b0, geom.h};

        // Both bounds are <= 160, so the low 8 bits hold them exactly.
        x_end = (x_sum > 9'(VIRT_W)) ? 8'(VIRT_W) : x_sum[7:0];
        y_end = (y_sum > 9'(VIRT_H)) ? 8'(VIRT_H) : y_sum[7:0];

        empty = (geom.w == 8'd0) || (geom.h == 8'd0) ||
                (geom.x0 >= 8'(VIRT_W)) || (geom.y0 >= 8'(VIRT_H));

        start_addr = ADDR_W'(geom.x0) * ADDR_W'(VIRT_H) + ADDR_W'(geom.y0);
    end

endmodule

// File: rtl/fb_rect_writer.sv
// ---------------------------------------------------------------------------
// fb_rect_writer
// Rectangle-fill drawing stage for the double-buffered 160x120 framebuffer.
// Accepts one command at a time, clips it, and streams one write per cycle
// (column-major: addr = x*VIRT_H + y, x outer, y inner) to the write port.
// Ports:
//   clk  : system clock
//   rst  : synchronous reset, active-high; forces every output to 0
//   bus  : fb_rect_writer_if.slave (command handshake, write stream,
//          busy/done status)
// ---------------------------------------------------------------------------
module fb_rect_writer
    import fb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    fb_rect_writer_if.slave    bus
);

    fill_state_t       state;
    fill_state_t       state_nxt;

    rect_cmd_t         cmd_q;
    logic [7:0]        x_q;
    logic [7:0]        y_q;
    logic [7:0]        x_end_q;
    logic [7:0]        y_end_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] col_step_q;

    logic [7:0]        clip_x_end;
    logic [7:0]        clip_y_end;
    logic              clip_empty;
    logic [ADDR_W-1:0] clip_start;

    logic              y_last;
    logic              x_last;
    logic              wr_fire;

    fb_rect_clip u_clip (
        .geom       (cmd_q.geom),
        .x_end      (clip_x_end),
        .y_end      (clip_y_end),
        .empty      (clip_empty),
        .start_addr (clip_start)
    );

    assign y_last  = (y_q == y_end_q - 8'd1);
    assign x_last  = (x_q == x_end_q - 8'd1);
    assign wr_fire = (state == ST_FILL) && bus.wr_ready;

    // ---------------- state register ----------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // ---------------- next-state logic ----------------
    // NOTE: the default assignment first keeps every path assigned, so no
    // latch is inferred when a case arm does not mention state_nxt.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (bus.cmd_valid) state_nxt = ST_SETUP;
            ST_SETUP: state_nxt = clip_empty ? ST_DONE : ST_FILL;
            ST_FILL:  if (wr_fire && y_last && x_last) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    // Everything is gated by rst so the block is silent during reset even on
    // the first reset cycle, before the state register has cleared.
    always_comb begin
        bus.cmd_ready = 1'b0;
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        if (!rst) begin
            bus.busy = (state != ST_IDLE);
            case (state)
                ST_IDLE: bus.cmd_ready = 1'b1;
                ST_FILL: begin
                    bus.wr_en   = 1'b1;
                    bus.wr_addr = addr_q;
                    bus.wr_data = cmd_q.color;
                end
                ST_DONE: bus.done = 1'b1;
                default: ;
            endcase
        end
    end

    // ---------------- datapath ----------------
    // The address walks incrementally: +1 down a column, then a jump of
    // VIRT_H - (rows - 1) to the top of the next column. The jump is fixed
    // per command, so it is computed once in SETUP.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            x_end_q    <= '0;
            y_end_q    <= '0;
            addr_q     <= '0;
            col_step_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        cmd_q.geom.x0 <= bus.cmd_x0;
                        cmd_q.geom.y0 <= bus.cmd_y0;
                        cmd_q.geom.w  <= bus.cmd_w;
                        cmd_q.geom.h  <= bus.cmd_h;
                        cmd_q.color   <= bus.cmd_color;
                    end
                end
                ST_SETUP: begin
                    x_q        <= cmd_q.geom.x0;
                    y_q        <= cmd_q.geom.y0;
                    x_end_q    <= clip_x_end;
                    y_end_q    <= clip_y_end;
                    addr_q     <= clip_start;
                    col_step_q <= ADDR_W'(VIRT_H)
                                - (ADDR_W'(clip_y_end) - ADDR_W'(cmd_q.geom.y0) - ADDR_W'(1));
                end
                ST_FILL: begin
                    if (bus.wr_ready) begin
                        if (y_last) begin
                            y_q    <= cmd_q.geom.y0;
                            x_q    <= x_q + 8'd1;
                            addr_q <= addr_q + col_step_q;
                        end else begin
                            y_q    <= y_q + 8'd1;
                            addr_q <= addr_q + ADDR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_rect_writer.sv
// ---------------------------------------------------------------------------
// tb_fb_rect_writer
// Self-checking bench for fb_rect_writer. The reference model enumerates the
// clipped rectangle's pixels directly (x outer, y inner, addr = x*VIRT_H+y)
// and the bench compares the observed write stream, latency and status
// signals against it.
// ---------------------------------------------------------------------------
module tb_fb_rect_writer;
    import fb_pkg::*;

    logic clk = 1'b0;
    logic rst;

    fb_rect_writer_if bus ();

    fb_rect_writer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #10 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: wr_ready always high; 1: random wr_ready;
    // 2: wr_ready low for 3 cycles after the second consumed write.
    // intrude: keep presenting junk commands while busy.
    // abort_at: if > 0, assert rst right after that many consumed writes.
    task automatic run_cmd(input string name,
                           input logic [7:0] x0, input logic [7:0] y0,
                           input logic [7:0] w,  input logic [7:0] h,
                           input logic [COLOR_W-1:0] color,
                           input int mode, input bit intrude, input int abort_at);
        int exp_q[$];
        int total;
        int ncons      = 0;
        int last_cyc   = -1;
        int first_cyc  = -1;
        int stall_left = 0;
        int budget;
        int ix0, iy0, xe, ye;
        bit rdy;
        bit done_seen  = 1'b0;

        // reference model
        ix0 = int'(x0);
        iy0 = int'(y0);
        xe  = (ix0 + int'(w) > VIRT_W) ? VIRT_W : ix0 + int'(w);
        ye  = (iy0 + int'(h) > VIRT_H) ? VIRT_H : iy0 + int'(h);
        for (int x = ix0; x < xe; x++)
            for (int y = iy0; y < ye; y++)
                exp_q.push_back(x * VIRT_H + y);
        total  = exp_q.size();
        budget = 4 * total + 20;

        for (int i = 0; i < 10 && !bus.cmd_ready; i++) tick();
        check({name, " cmd_ready_before"}, 32'(bus.cmd_ready), 32'd1);

        bus.cmd_valid = 1'b1;
        bus.cmd_x0    = x0;
        bus.cmd_y0    = y0;
        bus.cmd_w     = w;
        bus.cmd_h     = h;
        bus.cmd_color = color;
        bus.wr_ready  = 1'b0;
        tick();  // handshake cycle ends here (cycle 0)

        // Later input changes must not affect the running command.
        bus.cmd_valid = intrude;
        bus.cmd_x0    = 8'($urandom);
        bus.cmd_y0    = 8'($urandom);
        bus.cmd_w     = 8'($urandom);
        bus.cmd_h     = 8'($urandom);
        bus.cmd_color = COLOR_W'($urandom);

        for (int cyc = 1; cyc <= budget; cyc++) begin
            check({name, " busy"}, 32'(bus.busy), 32'd1);
            check({name, " cmd_ready_busy"}, 32'(bus.cmd_ready), 32'd0);
            if (bus.done) begin
                check({name, " done_cycle"}, cyc, (first_cyc < 0) ? 2 : last_cyc + 1);
                check({name, " wr_en_in_done"}, 32'(bus.wr_en), 32'd0);
                check({name, " write_count"}, ncons, total);
                bus.cmd_valid = 1'b0;
                bus.wr_ready  = 1'b0;
                done_seen     = 1'b1;
                tick();
                check({name, " done_one_cycle"}, 32'(bus.done), 32'd0);
                check({name, " cmd_ready_after"}, 32'(bus.cmd_ready), 32'd1);
                check({name, " busy_after"}, 32'(bus.busy), 32'd0);
                break;
            end
            if (bus.wr_en) begin
                if (first_cyc < 0) begin
                    first_cyc = cyc;
                    check({name, " first_wr_cycle"}, cyc, 2);
                end
                if (exp_q.size() == 0) begin
                    check({name, " extra_write"}, ncons + 1, total);
                end else begin
                    check({name, " wr_addr"}, 32'(bus.wr_addr), exp_q[0]);
                    check({name, " wr_data"}, 32'(bus.wr_data), 32'(color));
                end
                if (mode == 0)             rdy = 1'b1;
                else if (mode == 1)        rdy = ($urandom_range(0, 3) != 0);
                else if (stall_left > 0) begin
                    rdy = 1'b0;
                    stall_left--;
                end else                   rdy = 1'b1;
                bus.wr_ready = rdy;
                if (rdy) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    ncons++;
                    last_cyc = cyc;
                    if (mode == 2 && ncons == 2) stall_left = 3;
                    if (abort_at > 0 && ncons == abort_at) begin
                        rst           = 1'b1;
                        bus.cmd_valid = 1'b0;
                        tick();
                        check({name, " rst_wr_en"}, 32'(bus.wr_en), 32'd0);
                        check({name, " rst_done"}, 32'(bus.done), 32'd0);
                        check({name, " rst_cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
                        tick();
                        check({name, " rst_done_2"}, 32'(bus.done), 32'd0);
                        rst = 1'b0;
                        tick();
                        check({name, " post_rst_ready"}, 32'(bus.cmd_ready), 32'd1);
                        check({name, " post_rst_done"}, 32'(bus.done), 32'd0);
                        check({name, " post_rst_wr_en"}, 32'(bus.wr_en), 32'd0);
                        return;
                    end
                end
            end else begin
                bus.wr_ready = 1'($urandom_range(0, 1));
            end
            tick();
        end
        if (!done_seen) begin
            check({name, " done_timeout"}, 32'(done_seen), 32'd1);
            bus.cmd_valid = 1'b0;
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.cmd_valid = 1'b1;  // must be ignored during reset
        bus.cmd_x0    = 8'd0;
        bus.cmd_y0    = 8'd0;
        bus.cmd_w     = 8'd0;
        bus.cmd_h     = 8'd0;
        bus.cmd_color = '0;
        bus.wr_ready  = 1'b1;
        tick();
        tick();
        check("reset cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("reset wr_en", 32'(bus.wr_en), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset wr_addr", 32'(bus.wr_addr), 32'd0);
        bus.cmd_valid = 1'b0;
        rst           = 1'b0;
        tick();
        check("idle cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("idle busy", 32'(bus.busy), 32'd0);

        run_cmd("basic",     8'd2,   8'd3,   8'd2,   8'd3,   24'hFF0000, 0, 1'b0, 0);
        run_cmd("clip",      8'd158, 8'd118, 8'd5,   8'd5,   24'h00FF00, 0, 1'b0, 0);
        run_cmd("empty_w",   8'd10,  8'd10,  8'd0,   8'd5,   24'h123456, 0, 1'b0, 0);
        run_cmd("empty_x",   8'd160, 8'd10,  8'd5,   8'd5,   24'h654321, 0, 1'b0, 0);
        run_cmd("empty_h",   8'd10,  8'd10,  8'd5,   8'd0,   24'h0F0F0F, 0, 1'b0, 0);
        run_cmd("empty_y",   8'd10,  8'd120, 8'd5,   8'd5,   24'hF0F0F0, 0, 1'b0, 0);
        run_cmd("backpress", 8'd10,  8'd10,  8'd1,   8'd4,   24'h0000FF, 2, 1'b0, 0);
        run_cmd("full",      8'd0,   8'd0,   8'd255, 8'd255, 24'h000000, 0, 1'b1, 0);
        run_cmd("rst_mid",   8'd0,   8'd0,   8'd255, 8'd255, 24'hABCDEF, 0, 1'b0, 100);
        run_cmd("after_rst", 8'd5,   8'd7,   8'd3,   8'd2,   24'h112233, 0, 1'b0, 0);

        for (int n = 0; n < 20; n++) begin
            logic [7:0] rx0, ry0, rw, rh;
            rx0 = 8'($urandom_range(0, 170));
            ry0 = 8'($urandom_range(0, 130));
            rw  = ($urandom_range(0, 7) == 0) ? 8'd255 : 8'($urandom_range(0, 24));
            rh  = 8'($urandom_range(0, 24));
            run_cmd($sformatf("rand%0d", n), rx0, ry0, rw, rh,
                    COLOR_W'($urandom), 1, 1'($urandom_range(0, 1)), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
